// File: rtl/cdc_pkg.sv
// Shared helpers for gray-pointer clock-domain crossing: gray decode,
// multi-bit-step detection and legal synchroniser depth range.
package cdc_pkg;

  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;
  localparam int GRAY_MAX_W = 32;

  // Decodes the low w bits of g; bits at and above w come back as zero.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int w);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int i = GRAY_MAX_W-1; i >= 0; i--) begin
      if (i == w-1)    b[i] = g[i];
      else if (i < w-1) b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves something.
  function automatic logic popcount_gt1(input logic [GRAY_MAX_W-1:0] x);
    return (x & (x - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Bare synchroniser flop chain; kept in its own module so CDC constraints
// (ASYNC_REG etc.) can be attached to this hierarchy alone.
module sync_ff_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] stage_d, stage_q;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din;
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge wclk) begin
    if (wrst) stage_q <= '0;
    else      stage_q <= stage_d;
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/sync_ptr_cdc.sv
// Gray pointer synchroniser with registered binary decode, fill-valid flag,
// change pulse and illegal-step monitoring (sticky flag + saturating count).
module sync_ptr_cdc
  import cdc_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic [ADDRSIZE:0]    ptr_gray_in,
  input  logic                 err_clr,
  output logic [ADDRSIZE:0]    q_gray,
  output logic [ADDRSIZE:0]    q_bin,
  output logic                 q_valid,
  output logic                 ptr_changed,
  output logic                 gray_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int W        = ADDRSIZE + 1;
  localparam int FILL_MAX = SYNC_STAGES + 1;

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_stages
    $error("sync_ptr_cdc: SYNC_STAGES must be in 2..4");
  end

  sync_ff_chain #(.WIDTH(W), .STAGES(SYNC_STAGES)) u_chain (
    .wclk (wclk),
    .wrst (wrst),
    .din  (ptr_gray_in),
    .dout (q_gray)
  );

  logic [W-1:0]         q_bin_d, q_bin_q;
  logic [W-1:0]         prev_gray_d, prev_gray_q;
  logic [2:0]           fill_d, fill_q;
  logic                 ptr_changed_d, ptr_changed_q;
  logic                 gray_err_d, gray_err_q;
  logic [ERR_CNT_W-1:0] err_count_d, err_count_q;
  logic                 valid_d;
  logic                 illegal;

  assign q_valid = (fill_q == 3'(FILL_MAX));

  always_comb begin
    fill_d        = q_valid ? fill_q : fill_q + 3'd1;
    valid_d       = (fill_d == 3'(FILL_MAX));
    q_bin_d       = W'(gray2bin(GRAY_MAX_W'(q_gray), W));
    prev_gray_d   = q_gray;
    ptr_changed_d = valid_d && (q_gray != prev_gray_q);
    illegal       = q_valid && popcount_gt1(GRAY_MAX_W'(q_gray ^ prev_gray_q));
    gray_err_d    = gray_err_q;
    err_count_d   = err_count_q;
    // A fresh error outranks a simultaneous clear: the clear wipes history,
    // the new event is then counted as the first one.
    if (illegal) begin
      gray_err_d = 1'b1;
      if (err_clr)         err_count_d = ERR_CNT_W'(1);
      else if (!(&err_count_q)) err_count_d = err_count_q + 1'b1;
    end else if (err_clr) begin
      gray_err_d  = 1'b0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      q_bin_q       <= '0;
      prev_gray_q   <= '0;
      fill_q        <= '0;
      ptr_changed_q <= 1'b0;
      gray_err_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      q_bin_q       <= q_bin_d;
      prev_gray_q   <= prev_gray_d;
      fill_q        <= fill_d;
      ptr_changed_q <= ptr_changed_d;
      gray_err_q    <= gray_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign q_bin       = q_bin_q;
  assign ptr_changed = ptr_changed_q;
  assign gray_err    = gray_err_q;
  assign err_count   = err_count_q;

endmodule
